imem_imm_encoder: RTL

- Write-side counterpart of the ID-stage immediate extractor. Takes decoded instruction fields plus a full 32-bit immediate and packs them into RV32I words: U-type for LUI/AUIPC, I-type for OP-IMM/LOAD, S-type for STORE.
- Writes the packed words sequentially into instruction memory.
- Used by the program loader and self-test harness to fill IMEM.
- Supports a LI pseudo-op, which expands into one or two words (LUI+ADDI) through a small FSM.

---
 rtl/rv32i_pkg.sv | 42 ++++
 rtl/rv_imm_pack.sv | 28 ++
 rtl/imem_imm_encoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by both the immediate decoder and this
// encoder: base opcodes, funct3 values, request kinds, word formats and
// the signed 12-bit range check.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [2:0] {
        KIND_LI    = 3'd0,
        KIND_LUI   = 3'd1,
        KIND_AUIPC = 3'd2,
        KIND_OPIMM = 3'd3,
        KIND_LOAD  = 3'd4,
        KIND_STORE = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        FMT_U = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } enc_state_e;

    // True when v fits -2048..2047: bits 31..11 are all copies of the sign.
    function automatic logic is_s12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational RV32I word packer; inverse of the decoder's immediate
// extraction for U, I and S formats.
// Ports: fmt_i selects the layout; op_i/rd_i/rs1_i/rs2_i/f3_i/imm_i are the
// instruction fields; word_o is the packed 32-bit instruction.
module rv_imm_pack
    import rv32i_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  f3_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (fmt_i)
            FMT_U:   word_o = {imm_i[31:12], rd_i, op_i};
            FMT_I:   word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
            FMT_S:   word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/imem_imm_encoder.sv
// Packs decoded fields + 32-bit immediate into RV32I words and writes them
// sequentially into IMEM. LI expands into one or two words.
// Ports: clk/rst (sync, active-high); in_valid/in_ready handshake with
// in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm; addr_clr rewinds the
// write pointer; wr_en/wr_addr/wr_data drive IMEM; err pulses on a rejected
// request; wrapped is sticky once the pointer rolls over.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_EMIT1 | writing word 1
// ST_EMIT2 | writing word 2 (ADDI half of a split LI)
module imem_imm_encoder
    import rv32i_pkg::*;
#(
    parameter int unsigned           ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic              wrapped
);

    enc_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrapped_q, wrapped_d;
    logic              two_q, two_d;
    logic [31:0]       word2_q, word2_d;

    fmt_e        fmt1;
    logic [6:0]  op1;
    logic [4:0]  rs1_1;
    logic [2:0]  f3_1;
    logic [31:0] imm1;
    logic        legal;
    logic        two_word;
    logic [31:0] word1;
    logic [31:0] word2;
    logic        accept;

    assign accept = in_valid & ready_q;

    // Request decode: word-1 fields, legality and whether LI needs a split.
    always_comb begin
        fmt1     = FMT_I;
        op1      = OPC_OP_IMM;
        rs1_1    = in_rs1;
        f3_1     = in_funct3;
        imm1     = in_imm;
        legal    = 1'b0;
        two_word = 1'b0;
        case (in_kind)
            KIND_LI: begin
                legal = 1'b1;
                if (is_s12(in_imm)) begin
                    rs1_1 = 5'd0;
                    f3_1  = F3_ADDI;
                end else begin
                    fmt1 = FMT_U;
                    op1  = OPC_LUI;
                    if (in_imm[11:0] != 12'd0) begin
                        // Pre-add 0x800 so the sign-extended ADDI low half
                        // lands back on the requested value.
                        imm1     = in_imm + 32'h0000_0800;
                        two_word = 1'b1;
                    end
                end
            end
            KIND_LUI, KIND_AUIPC: begin
                fmt1  = FMT_U;
                op1   = (in_kind == KIND_LUI) ? OPC_LUI : OPC_AUIPC;
                legal = (in_imm[11:0] == 12'd0);
            end
            KIND_OPIMM, KIND_LOAD: begin
                op1   = (in_kind == KIND_OPIMM) ? OPC_OP_IMM : OPC_LOAD;
                legal = is_s12(in_imm);
            end
            KIND_STORE: begin
                fmt1  = FMT_S;
                op1   = OPC_STORE;
                legal = is_s12(in_imm);
            end
            default: legal = 1'b0;
        endcase
    end

    rv_imm_pack u_pack1 (
        .fmt_i  (fmt1),
        .op_i   (op1),
        .rd_i   (in_rd),
        .rs1_i  (rs1_1),
        .rs2_i  (in_rs2),
        .f3_i   (f3_1),
        .imm_i  (imm1),
        .word_o (word1)
    );

    // Second word is always ADDI rd,rd,lo.
    rv_imm_pack u_pack2 (
        .fmt_i  (FMT_I),
        .op_i   (OPC_OP_IMM),
        .rd_i   (in_rd),
        .rs1_i  (in_rd),
        .rs2_i  (in_rs2),
        .f3_i   (F3_ADDI),
        .imm_i  (in_imm),
        .word_o (word2)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        two_d     = two_q;
        word2_d   = word2_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d   = ST_EMIT1;
                        wr_en_d   = 1'b1;
                        wr_data_d = word1;
                        two_d     = two_word;
                        word2_d   = word2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT1: begin
                if (two_q) begin
                    state_d   = ST_EMIT2;
                    wr_en_d   = 1'b1;
                    wr_data_d = word2_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Pointer follows the registered strobe, so a write always uses the
    // address visible in its own cycle; a clear in that cycle still wins.
    always_comb begin
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        if (wr_en_q) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (&ptr_q) begin
                wrapped_d = 1'b1;
            end
        end
        if (addr_clr) begin
            ptr_d     = BASE_ADDR;
            wrapped_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            ptr_q     <= BASE_ADDR;
            wrapped_q <= 1'b0;
            two_q     <= 1'b0;
            word2_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            two_q     <= two_d;
            word2_q   <= word2_d;
        end
    end

    assign in_ready = ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = ptr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign wrapped  = wrapped_q;

endmodule
